// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions for the display encoder and scan decoder paths.
// Segment order is {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

    typedef enum logic {
        TRACK,
        COMMITTED
    } sampler_state_t;

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_t;

endpackage

// File: rtl/sevenseg_to_bcd.sv
// Combinational decoder from an active-low segment pattern back to BCD.
// Blank reads as BCD_BLANK; any unrecognised pattern reads as BCD_INVALID.
module sevenseg_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        bcd     = BCD_INVALID;
        blank   = 1'b0;
        invalid = 1'b0;
        case (segment)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                bcd   = BCD_BLANK;
                blank = 1'b1;
            end
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Observes a multiplexed active-low seven-segment bus, debounces each digit slot,
// and hands complete multi-digit frames out on a valid/ready interface.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 3
)
(
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   digit_sel_L,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    error,
    output logic                    overrun,
    input  logic                    clear
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam int PW = NUM_DIGITS + 7;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    sampler_state_t        state_reg, state_next;
    out_state_t            out_state_reg, out_state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [PW-1:0]         pair_reg;
    logic [NUM_DIGITS-1:0] seen_reg, seen_next;
    logic                  complete_reg, complete_next;
    logic                  err_pend_reg;
    logic                  error_reg, error_next;
    logic                  overrun_reg, overrun_next;

    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] seen_or;
    logic [PW-1:0]         pair;
    logic                  sel_onehot;
    logic                  same_pair;
    logic                  commit;
    logic                  load;
    logic                  drop;
    logic [3:0]            dec_bcd;
    logic                  dec_blank;
    logic                  dec_invalid;

    sevenseg_to_bcd u_decode (
        .segment (segment),
        .bcd     (dec_bcd),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    assign sel        = ~digit_sel_L;
    assign sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    assign pair       = {digit_sel_L, segment};
    assign same_pair  = (pair == pair_reg);
    assign seen_or    = seen_reg | sel;

    // Sampler: a digit commits once the same pair has been seen STABLE_COUNT times in a row.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        if (!sel_onehot) begin
            state_next = TRACK;
            count_next = '0;
        end else if (!same_pair || count_reg == '0) begin
            state_next = TRACK;
            count_next = CW'(1);
            if (STABLE_COUNT == 1) begin
                commit     = 1'b1;
                state_next = COMMITTED;
            end
        end else if (state_reg == TRACK) begin
            if (count_reg == CW'(STABLE_COUNT - 1)) begin
                commit     = 1'b1;
                state_next = COMMITTED;
                count_next = CW'(STABLE_COUNT);
            end else begin
                count_next = count_reg + CW'(1);
            end
        end
    end

    // Frame completion is registered; the load decision happens one edge later.
    always_comb begin
        seen_next     = seen_reg;
        complete_next = 1'b0;
        if (commit) begin
            if (&seen_or) begin
                seen_next     = '0;
                complete_next = 1'b1;
            end else begin
                seen_next = seen_or;
            end
        end
    end

    always_comb begin
        out_state_next = out_state_reg;
        load           = 1'b0;
        drop           = 1'b0;
        if (complete_reg) begin
            if (out_state_reg == EMPTY || frame_ready) begin
                load = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        case (out_state_reg)
            EMPTY:   if (load) out_state_next = FULL;
            FULL:    if (frame_ready && !load) out_state_next = EMPTY;
            default: out_state_next = EMPTY;
        endcase
    end

    // Sticky flags: a set event in the same cycle as clear takes priority.
    always_comb begin
        error_next   = error_reg;
        overrun_next = overrun_reg;
        if (clear) begin
            error_next   = 1'b0;
            overrun_next = 1'b0;
        end
        if (err_pend_reg) error_next = 1'b1;
        if (drop) overrun_next = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg     <= TRACK;
            count_reg     <= '0;
            pair_reg      <= '1;
            seen_reg      <= '0;
            complete_reg  <= 1'b0;
            err_pend_reg  <= 1'b0;
            out_state_reg <= EMPTY;
            error_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            pair_reg      <= pair;
            seen_reg      <= seen_next;
            complete_reg  <= complete_next;
            err_pend_reg  <= commit && dec_invalid;
            out_state_reg <= out_state_next;
            error_reg     <= error_next;
            overrun_reg   <= overrun_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] shadow_bcd_reg;
            logic       shadow_blank_reg;
            logic [3:0] out_bcd_reg;
            logic       out_blank_reg;

            always_ff @(posedge clock or negedge reset_L) begin
                if (!reset_L) begin
                    shadow_bcd_reg   <= BCD_BLANK;
                    shadow_blank_reg <= 1'b1;
                    out_bcd_reg      <= BCD_BLANK;
                    out_blank_reg    <= 1'b1;
                end else begin
                    if (commit && sel[gi]) begin
                        shadow_bcd_reg   <= dec_bcd;
                        shadow_blank_reg <= dec_blank;
                    end
                    if (load) begin
                        out_bcd_reg   <= shadow_bcd_reg;
                        out_blank_reg <= shadow_blank_reg;
                    end
                end
            end

            assign bcd_out[4*gi +: 4] = out_bcd_reg;
            assign blank_out[gi]      = out_blank_reg;
        end
    endgenerate

    assign frame_valid = (out_state_reg == FULL);
    assign error       = error_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: stimulus queues expected frames,
// a monitor pops and compares on every valid/ready transfer.
module tb_sevenseg_scan_decoder;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001101;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b0110110;
    localparam logic [6:0] PM = 7'b1111110;

    logic        clock = 1'b0;
    logic        reset_L;
    logic [6:0]  segment;
    logic [3:0]  digit_sel_L;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        frame_valid;
    logic        frame_ready;
    logic        error;
    logic        overrun;
    logic        clear;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
    } frame_t;

    frame_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sevenseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_COUNT(3)) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .segment     (segment),
        .digit_sel_L (digit_sel_L),
        .bcd_out     (bcd_out),
        .blank_out   (blank_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .error       (error),
        .overrun     (overrun),
        .clear       (clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic show(input int slot, input logic [6:0] s, input int n);
        digit_sel_L = ~(4'b0001 << slot);
        segment     = s;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        digit_sel_L = 4'hF;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int n);
        show(0, s0, n);
        show(1, s1, n);
        show(2, s2, n);
        show(3, s3, n);
    endtask

    // Monitor: every cycle that presents valid with ready is one transfer.
    always @(negedge clock) begin
        frame_t e;
        if (reset_L && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected: got bcd=%h blank=%b want no frame", bcd_out, blank_out);
            end else begin
                e = exp_q.pop_front();
                check("frame_bcd", 32'(bcd_out), 32'(e.bcd));
                check("frame_blank", 32'(blank_out), 32'(e.blank));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_L     = 1'b0;
        segment     = PB;
        digit_sel_L = 4'hF;
        frame_ready = 1'b0;
        clear       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_bcd", 32'(bcd_out), 32'hFFFF);
        check("rst_blank", 32'(blank_out), 32'hF);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_error", 32'(error), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_L = 1'b1;
        idle(2);

        // Basic scan 1,2,3,4 with ready high
        frame_ready = 1'b1;
        exp_q.push_back('{bcd: 16'h4321, blank: 4'b0000});
        scan(P1, P2, P3, P4, 3);
        digit_sel_L = 4'hF;
        @(negedge clock); check("s1_valid_pre", 32'(frame_valid), 0);
        @(negedge clock); check("s1_valid_load", 32'(frame_valid), 1);
        @(negedge clock); check("s1_valid_drop", 32'(frame_valid), 0);
        check("s1_error", 32'(error), 0);
        idle(2);

        // Two-cycle holds never commit
        frame_ready = 1'b0;
        scan(P5, P6, P7, P8, 2);
        scan(P5, P6, P7, P8, 2);
        idle(3);
        check("s2_short_valid", 32'(frame_valid), 0);
        frame_ready = 1'b1;
        exp_q.push_back('{bcd: 16'h8765, blank: 4'b0000});
        scan(P5, P6, P7, P8, 3);
        idle(4);

        // Invalid and blank digits, then clear
        exp_q.push_back('{bcd: 16'h8F1E, blank: 4'b0100});
        show(0, PX, 3);
        check("s3_err_not_yet", 32'(error), 0);
        digit_sel_L = 4'b1101;
        segment     = P1;
        @(posedge clock); #1;
        check("s3_err_set", 32'(error), 1);
        repeat (2) @(posedge clock); #1;
        show(2, PB, 3);
        show(3, P8, 3);
        idle(4);
        check("s3_err_sticky", 32'(error), 1);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("s3_err_cleared", 32'(error), 0);

        // Backpressure: second frame dropped
        frame_ready = 1'b0;
        exp_q.push_back('{bcd: 16'h9765, blank: 4'b0000});
        scan(P5, P6, P7, P9, 3);
        idle(2);
        check("s4_valid_a", 32'(frame_valid), 1);
        check("s4_bcd_a", 32'(bcd_out), 32'h9765);
        check("s4_ovr_clear", 32'(overrun), 0);
        scan(P0, P1, P2, P3, 3);
        idle(2);
        check("s4_ovr_set", 32'(overrun), 1);
        check("s4_valid_held", 32'(frame_valid), 1);
        check("s4_bcd_held", 32'(bcd_out), 32'h9765);
        frame_ready = 1'b1;
        @(posedge clock); #1;
        check("s4_valid_after_xfer", 32'(frame_valid), 0);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("s4_ovr_cleared", 32'(overrun), 0);
        check("s4_error_clean", 32'(error), 0);

        // Select glitches restart the stability count
        exp_q.push_back('{bcd: 16'h9873, blank: 4'b0000});
        show(1, P7, 3);
        show(2, P8, 3);
        show(3, P9, 3);
        show(0, P3, 2);
        digit_sel_L = 4'b1100;
        @(posedge clock); #1;
        show(0, P3, 2);
        idle(3);
        check("s5_glitch_no_frame", 32'(frame_valid), 0);
        show(0, P3, 2);
        digit_sel_L = 4'b1111;
        @(posedge clock); #1;
        show(0, P3, 3);
        digit_sel_L = 4'hF;
        @(negedge clock); check("s5_valid_pre", 32'(frame_valid), 0);
        @(negedge clock); check("s5_valid_load", 32'(frame_valid), 1);
        idle(3);

        // Asynchronous reset mid-scan discards the partial frame
        frame_ready = 1'b0;
        scan(P0, PM, P5, P2, 3);
        idle(3);
        check("s6_valid_pre", 32'(frame_valid), 1);
        check("s6_error_pre", 32'(error), 1);
        show(0, P4, 3);
        show(1, P4, 3);
        show(2, P6, 1);
        #3;
        reset_L = 1'b0;
        #1;
        check("s6_rst_bcd", 32'(bcd_out), 32'hFFFF);
        check("s6_rst_blank", 32'(blank_out), 32'hF);
        check("s6_rst_valid", 32'(frame_valid), 0);
        check("s6_rst_error", 32'(error), 0);
        check("s6_rst_overrun", 32'(overrun), 0);
        @(posedge clock); #1;
        reset_L = 1'b1;
        show(2, P6, 3);
        show(3, P1, 3);
        frame_ready = 1'b1;
        idle(5);
        check("s6_no_partial", 32'(frame_valid), 0);
        check("s6_bcd_reset", 32'(bcd_out), 32'hFFFF);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
# sevenseg_scan_decoder

- Receive side of the display path: observes a time-multiplexed, active-low seven-segment bus (shared segment lines plus per-digit select).
- Debounces each digit slot and decodes segment patterns back to BCD.
- Presents one complete multi-digit frame at a time on a valid/ready output.
- Sits between the display-driver pins (or a display-driver model) and any checker or readback logic needing the numeric value shown.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit slots (≥1).
- STABLE_COUNT, 3, consecutive identical samples required before a digit is committed (≥1).
- clock  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset. Asserts asynchronously; deasserts synchronously to clock.
- segment  input  7  {a,b,c,d,e,f,g}, active-low.
- digit_sel_L  input  NUM_DIGITS  active-low one-hot digit enable. Bit i low means the bus shows digit i.
- bcd_out  output  4*NUM_DIGITS  digit i in bits [4i+3:4i].
- blank_out  output  NUM_DIGITS  bit i = digit i was blank (all segments off).
- frame_valid  output  1  bcd_out/blank_out hold a complete frame.
- frame_ready  input  1  consumer accepts the frame.
- error  output  1  sticky; some committed digit pattern was not 0–9 or blank.
- overrun  output  1  sticky; a completed frame was dropped.
- clear  input  1  synchronous clear of error and overrun.

## Operation
- Decode table (segment to BCD):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001101→7, 0000000→8, 0000100→9
  - 1111111→4'hF with blank bit set
  - any other pattern → 4'hE, and error is set
- Each cycle, sample the pair {digit_sel_L, segment}.
  - If digit_sel_L is not exactly one-hot low (none selected or several selected), the sample is ignored and the sampler returns to TRACK with count 0.
- Sampler FSM:
  - TRACK: if the pair equals the previous cycle's pair, count++. Otherwise count=1.
  - When count reaches STABLE_COUNT, commit the decoded digit into shadow slot i, set seen[i], and go to COMMITTED.
  - COMMITTED: no further commits. Any change of the pair goes to TRACK with count=1.
  - Re-committing a slot already in seen overwrites it (latest value wins).
- Frame completion occurs when seen is all ones after a commit. Then seen clears and:
  - frame_valid=0, or frame_ready=1 in the same cycle: load shadow into bcd_out/blank_out and set frame_valid=1.
  - frame_valid=1 and frame_ready=0: frame dropped, overrun=1, outputs unchanged.
- Output FSM:
  - EMPTY→FULL on load.
  - FULL→EMPTY on frame_ready with no simultaneous load.
  - FULL stays FULL on simultaneous ready and load.
- bcd_out/blank_out are stable while frame_valid=1.
- clear zeroes error and overrun. A set event in the same cycle wins.

## Timing
- Reset values:
  - bcd_out all 4'hF, blank_out all 1
  - frame_valid 0, error 0, overrun 0
  - seen 0, sampler in TRACK with count 0
- Reset mid-frame discards the partial frame.
- Commit latency: a pair first presented at edge t commits at edge t+STABLE_COUNT-1. With STABLE_COUNT=1 it commits at edge t.
- Frame load: bcd_out, blank_out and frame_valid update at the edge after the final digit's commit (1-cycle registered completion).
- Handshake: transfer at any edge with frame_valid=1 and frame_ready=1. frame_valid falls the following cycle unless a load coincides.
- error sets at the edge after the committing edge of an invalid digit.

## Structure
- Package sevenseg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants
  - BCD_BLANK=4'hF and BCD_INVALID=4'hE
  - sampler_state_t {TRACK, COMMITTED} and out_state_t {EMPTY, FULL}
- The package is shared with the existing encoder path.
- Sub-module: sevenseg_to_bcd, a combinational pattern decoder producing {bcd[3:0], blank, invalid}.

## Test plan
All scenarios use NUM_DIGITS=4 and STABLE_COUNT=3.

- Scan digits 0–3 showing 1,2,3,4, each held 3 cycles, with frame_ready=1 → bcd_out=16'h4321, blank_out=0000, frame_valid pulses 1 cycle, error=0.
- Hold each slot only 2 cycles → no commit, frame_valid stays 0. Repeat with 3 cycles → frame loads.
- Slot 2 shows 1111111 and slot 0 shows 0110110 → nibble 2=4'hF, blank_out[2]=1, nibble 0=4'hE, error=1. Pulse clear → error=0.
- Hold frame_ready=0 across two full scans → first frame held, overrun=1, bcd_out unchanged. Raise frame_ready → frame_valid drops next cycle.
- digit_sel_L=4'b1100 or 4'b1111 in mid-hold → count restarts and commit is delayed by the full STABLE_COUNT.
- Assert reset_L low mid-scan → all outputs at reset values immediately, and the partial frame is not emitted after release.
